// File: rtl/dmem_lsu.sv
// RV32I data memory for the MEM stage: byte/half/word loads and stores with
// sign/zero extension, misalignment rejection, registered read and post-reset clear.
module dmem_lsu #(
    parameter int DEPTH_WORDS = 256,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        misalign_fault,
    output logic        busy,
    output logic [1:0]  dbgState
);

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1
    } lsuState;

    lsuState          state, nextState;
    logic [IDX_W-1:0] cnt, nextCnt;
    logic             clearWe;

    logic [31:0]      mem [DEPTH_WORDS];

    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             legal, aligned, active, accept, reject;
    logic [3:0]       byteEn;
    logic [31:0]      storeData;
    logic [31:0]      memWord, loadVal;
    logic [7:0]       byteVal;
    logic [15:0]      halfVal;
    logic             unusedAddr;

    assign idx        = addr[IDX_W+1:2];
    assign lane       = addr[1:0];
    assign unusedAddr = ^addr[31:IDX_W+2];
    assign busy       = (state != IDLE);
    assign dbgState   = state;

    // Clear sequencer: one zero word per cycle, then hand over to IDLE.
    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        clearWe   = 1'b0;
        case (state)
            INIT: begin
                clearWe = 1'b1;
                nextCnt = cnt + IDX_W'(1);
                if (cnt == IDX_W'(DEPTH_WORDS - 1)) begin
                    nextState = IDLE;
                    nextCnt   = '0;
                end
            end
            IDLE: nextState = IDLE;
            default: nextState = INIT;
        endcase
    end

    always_comb begin
        legal = we ? (funct3 inside {3'b000, 3'b001, 3'b010})
                   : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        case (funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        active = req && !busy;
        accept = active && legal && aligned;
        reject = active && !(legal && aligned);
    end

    // Replicate the store data across lanes so the byte enables pick the right copy.
    always_comb begin
        byteEn    = 4'b0000;
        storeData = wdata;
        case (funct3[1:0])
            2'b00: begin
                byteEn    = 4'b0001 << lane;
                storeData = {4{wdata[7:0]}};
            end
            2'b01: begin
                byteEn    = addr[1] ? 4'b1100 : 4'b0011;
                storeData = {2{wdata[15:0]}};
            end
            2'b10: byteEn = 4'b1111;
            default: byteEn = 4'b0000;
        endcase
    end

    always_comb begin
        memWord = mem[idx];
        byteVal = memWord[{lane, 3'b000} +: 8];
        halfVal = addr[1] ? memWord[31:16] : memWord[15:0];
        case (funct3)
            3'b000:  loadVal = {{24{byteVal[7]}}, byteVal};
            3'b001:  loadVal = {{16{halfVal[15]}}, halfVal};
            3'b100:  loadVal = {24'b0, byteVal};
            3'b101:  loadVal = {16'b0, halfVal};
            default: loadVal = memWord;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= INIT;
            cnt            <= '0;
            rdata          <= '0;
            rvalid         <= 1'b0;
            misalign_fault <= 1'b0;
        end else begin
            state          <= nextState;
            cnt            <= nextCnt;
            rvalid         <= accept && !we;
            misalign_fault <= reject;
            if (accept && !we) begin
                rdata <= loadVal;
            end
        end
    end

    // Storage has no reset; contents are defined by the clear sequence instead.
    always_ff @(posedge clk) begin
        if (clearWe) begin
            mem[cnt] <= '0;
        end else if (accept && we) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    mem[idx][8*i +: 8] <= storeData[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu (16 words): directed scenarios plus randomized traffic
// checked against a word-array reference model.
module tb_dmem_lsu;
    localparam int DW = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        misalign_fault;
    logic        busy;
    logic [1:0]  dbg_state;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_mem [DW];
    logic [31:0] exp_q [$];
    logic [31:0] last_rdata = '0;

    always #5 clk = ~clk;

    dmem_lsu #(.DEPTH_WORDS(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .funct3(funct3), .rdata(rdata), .rvalid(rvalid), .misalign_fault(misalign_fault),
        .busy(busy), .dbgState(dbg_state)
    );

    // ---------------- reference model ----------------
    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DW);
    endfunction

    function automatic bit model_ok(input logic w, input logic [31:0] a, input logic [2:0] f);
        bit legal;
        int sz;
        if (w) legal = (f <= 2);
        else   legal = (f <= 2) || (f == 4) || (f == 5);
        sz = (f % 4 == 0) ? 1 : (f % 4 == 1) ? 2 : 4;
        return legal && (a % sz == 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f);
        logic [31:0] w, b, h;
        int sh, hs;
        w  = model_mem[widx(a)];
        sh = int'(a % 4) * 8;
        hs = (int'(a % 4) / 2) * 16;
        b  = (w >> sh) & 32'hFF;
        h  = (w >> hs) & 32'hFFFF;
        case (f)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        logic [31:0] w, mask;
        int sh, hs;
        w  = model_mem[widx(a)];
        sh = int'(a % 4) * 8;
        hs = (int'(a % 4) / 2) * 16;
        case (f)
            3'd0: begin mask = 32'hFF << sh;   w = (w & ~mask) | ((d & 32'hFF) << sh); end
            3'd1: begin mask = 32'hFFFF << hs; w = (w & ~mask) | ((d & 32'hFFFF) << hs); end
            default: w = d;
        endcase
        model_mem[widx(a)] = w;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DW; i++) model_mem[i] = '0;
    endtask

    // ---------------- drivers ----------------
    task automatic drive_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] f);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; funct3 = f;
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic drive_idle();
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_clear(output int edges);
        edges = 0;
        while (edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (!busy) break;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int edges;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy: got %0b want 1", busy); end
        checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid: got %0b want 0", rvalid); end
        checks++; if (misalign_fault !== 1'b0) begin failures++; $display("FAIL reset_fault: got %0b want 0", misalign_fault); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        wait_clear(edges);
        checks++; if (edges != DW) begin failures++; $display("FAIL clear_length: got %0d edges want %0d", edges, DW); end
        for (int i = 0; i < DW; i++) begin
            drive_access(1'b0, 32'(i * 4), 32'h0, 3'b010);
            checks++; if (rvalid !== 1'b1) begin failures++; $display("FAIL clear_rvalid[%0d]: got %0b want 1", i, rvalid); end
            checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL clear_rdata[%0d]: got %h want 0", i, rdata); end
        end
        last_rdata = '0;
    endtask

    task automatic test_word_roundtrip();
        drive_access(1'b1, 32'h08, 32'h9302_9203, 3'b010);
        model_store(32'h08, 32'h9302_9203, 3'b010);
        checks++; if (rvalid !== 1'b0 || misalign_fault !== 1'b0) begin failures++; $display("FAIL sw_flags: got rvalid=%0b fault=%0b want 0/0", rvalid, misalign_fault); end
        drive_access(1'b0, 32'h08, 32'h0, 3'b010);
        checks++; if (rvalid !== 1'b1) begin failures++; $display("FAIL lw_rvalid: got %0b want 1", rvalid); end
        checks++; if (rdata !== 32'h9302_9203) begin failures++; $display("FAIL lw_rdata: got %h want 93029203", rdata); end
        drive_idle();
        checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL lw_pulse: got %0b want 0", rvalid); end
        checks++; if (rdata !== 32'h9302_9203) begin failures++; $display("FAIL lw_hold: got %h want 93029203", rdata); end
        last_rdata = 32'h9302_9203;
    endtask

    task automatic test_byte_half();
        logic [31:0] ta [5] = '{32'h08, 32'h09, 32'h09, 32'h0A, 32'h0A};
        logic [2:0]  tf [5] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] te [5] = '{32'h8001_AA03, 32'hFFFF_FFAA, 32'h0000_00AA, 32'hFFFF_8001, 32'h0000_8001};
        drive_access(1'b1, 32'h09, 32'h0000_00AA, 3'b000);
        model_store(32'h09, 32'h0000_00AA, 3'b000);
        drive_access(1'b1, 32'h0A, 32'h0000_8001, 3'b001);
        model_store(32'h0A, 32'h0000_8001, 3'b001);
        for (int i = 0; i < 5; i++) begin
            drive_access(1'b0, ta[i], 32'h0, tf[i]);
            checks++; if (rvalid !== 1'b1 || rdata !== te[i]) begin failures++; $display("FAIL ext_load[%0d]: got rvalid=%0b rdata=%h want 1/%h", i, rvalid, rdata, te[i]); end
        end
        last_rdata = te[4];
    endtask

    task automatic test_misalign();
        drive_access(1'b1, 32'h0A, 32'hDEAD_BEEF, 3'b010);
        checks++; if (misalign_fault !== 1'b1 || rvalid !== 1'b0) begin failures++; $display("FAIL sw_misalign: got fault=%0b rvalid=%0b want 1/0", misalign_fault, rvalid); end
        drive_idle();
        checks++; if (misalign_fault !== 1'b0) begin failures++; $display("FAIL fault_pulse: got %0b want 0", misalign_fault); end
        drive_access(1'b0, 32'h08, 32'h0, 3'b010);
        checks++; if (rdata !== 32'h8001_AA03) begin failures++; $display("FAIL sw_misalign_nowrite: got %h want 8001aa03", rdata); end
        drive_access(1'b0, 32'h05, 32'h0, 3'b001);
        checks++; if (misalign_fault !== 1'b1 || rvalid !== 1'b0) begin failures++; $display("FAIL lh_misalign: got fault=%0b rvalid=%0b want 1/0", misalign_fault, rvalid); end
        checks++; if (rdata !== 32'h8001_AA03) begin failures++; $display("FAIL lh_misalign_hold: got %h want 8001aa03", rdata); end
        drive_access(1'b0, 32'h0C, 32'h0, 3'b011);
        checks++; if (misalign_fault !== 1'b1 || rvalid !== 1'b0) begin failures++; $display("FAIL illegal_load: got fault=%0b rvalid=%0b want 1/0", misalign_fault, rvalid); end
        drive_access(1'b1, 32'h0C, 32'h0000_0055, 3'b100);
        checks++; if (misalign_fault !== 1'b1) begin failures++; $display("FAIL illegal_store: got %0b want 1", misalign_fault); end
        drive_access(1'b0, 32'h0C, 32'h0, 3'b010);
        checks++; if (rdata !== model_load(32'h0C, 3'b010)) begin failures++; $display("FAIL illegal_store_nowrite: got %h want %h", rdata, model_load(32'h0C, 3'b010)); end
        drive_access(1'b1, 32'h07, 32'h0000_005A, 3'b000);
        model_store(32'h07, 32'h0000_005A, 3'b000);
        checks++; if (misalign_fault !== 1'b0) begin failures++; $display("FAIL sb_odd_accept: got %0b want 0", misalign_fault); end
        drive_access(1'b0, 32'h04, 32'h0, 3'b010);
        checks++; if (rdata !== 32'h5A00_0000) begin failures++; $display("FAIL sb_odd_data: got %h want 5a000000", rdata); end
        last_rdata = 32'h5A00_0000;
    endtask

    task automatic test_alias_busy();
        int edges;
        drive_access(1'b1, 32'h40, 32'h1234_5678, 3'b010);
        model_store(32'h40, 32'h1234_5678, 3'b010);
        drive_access(1'b0, 32'h00, 32'h0, 3'b010);
        checks++; if (rdata !== 32'h1234_5678) begin failures++; $display("FAIL alias_load: got %h want 12345678", rdata); end
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            drive_access(1'b1, 32'h00, 32'hA5A5_A5A5, 3'b010);
            checks++; if (busy !== 1'b1 || rvalid !== 1'b0 || misalign_fault !== 1'b0) begin failures++; $display("FAIL busy_store[%0d]: got busy=%0b rvalid=%0b fault=%0b want 1/0/0", i, busy, rvalid, misalign_fault); end
        end
        drive_access(1'b0, 32'h00, 32'h0, 3'b011);
        checks++; if (rvalid !== 1'b0 || misalign_fault !== 1'b0) begin failures++; $display("FAIL busy_load: got rvalid=%0b fault=%0b want 0/0", rvalid, misalign_fault); end
        wait_clear(edges);
        checks++; if (edges != 11) begin failures++; $display("FAIL busy_clear_len: got %0d edges want 11", edges); end
        drive_access(1'b0, 32'h00, 32'h0, 3'b010);
        checks++; if (rvalid !== 1'b1 || rdata !== 32'h0) begin failures++; $display("FAIL busy_nowrite: got rvalid=%0b rdata=%h want 1/0", rvalid, rdata); end
        last_rdata = '0;
    endtask

    task automatic test_reset_mid();
        int edges;
        drive_access(1'b1, 32'h10, 32'hCAFE_F00D, 3'b010);
        drive_access(1'b0, 32'h10, 32'h0, 3'b010);
        checks++; if (rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL pre_reset_load: got %h want cafef00d", rdata); end
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h10; funct3 = 3'b010;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rdata !== 32'h0 || busy !== 1'b1) begin failures++; $display("FAIL async_reset: got rdata=%h busy=%0b want 0/1", rdata, busy); end
        @(posedge clk);
        #1;
        req = 1'b0;
        checks++; if (rvalid !== 1'b0 || rdata !== 32'h0) begin failures++; $display("FAIL reset_mid_load: got rvalid=%0b rdata=%h want 0/0", rvalid, rdata); end
        @(negedge clk) rst_n = 1'b1;
        model_clear();
        repeat (5) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        wait_clear(edges);
        checks++; if (edges != DW) begin failures++; $display("FAIL reset_mid_clear: got %0d edges want %0d", edges, DW); end
        drive_access(1'b0, 32'h10, 32'h0, 3'b010);
        checks++; if (rvalid !== 1'b1 || rdata !== 32'h0) begin failures++; $display("FAIL reset_mid_cleared: got rvalid=%0b rdata=%h want 1/0", rvalid, rdata); end
        last_rdata = '0;
    endtask

    task automatic test_random();
        logic        w;
        logic [2:0]  f;
        logic [31:0] a, d, e;
        bit          ok;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                drive_idle();
                checks++; if (rvalid !== 1'b0 || misalign_fault !== 1'b0) begin failures++; $display("FAIL rnd_idle[%0d]: got rvalid=%0b fault=%0b want 0/0", n, rvalid, misalign_fault); end
                continue;
            end
            w = 1'($urandom_range(0, 1));
            f = 3'($urandom_range(0, 7));
            a = $urandom_range(0, 3) == 0 ? $urandom() : 32'($urandom_range(0, 4 * DW - 1));
            d = $urandom();
            ok = model_ok(w, a, f);
            if (ok && !w) exp_q.push_back(model_load(a, f));
            if (ok && w) model_store(a, d, f);
            drive_access(w, a, d, f);
            checks++; if (misalign_fault !== !ok || rvalid !== (ok && !w)) begin failures++; $display("FAIL rnd_flags[%0d]: got fault=%0b rvalid=%0b want %0b/%0b (we=%0b f3=%0d addr=%h)", n, misalign_fault, rvalid, !ok, ok && !w, w, f, a); end
            if (ok && !w) begin
                e = exp_q.pop_front();
                last_rdata = e;
            end else begin
                e = last_rdata;
            end
            checks++; if (rdata !== e) begin failures++; $display("FAIL rnd_rdata[%0d]: got %h want %h (we=%0b f3=%0d addr=%h)", n, rdata, e, w, f, a); end
        end
    endtask

    initial begin
        #300000;
        failures++;
        $display("FAIL watchdog: got timeout want completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_word_roundtrip();
        test_byte_half();
        test_misalign();
        test_alias_busy();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
